// File: rtl/stream_checker.sv
// Sequence checker for a counting stream: accepts beats with a ready/valid handshake,
// tracks the expected next value, and counts accepted beats and mismatches.
// Optional ready-low stall after each beat is enabled by STREAM_CHECKER_STALL_EN.
module stream_checker #(
  parameter int unsigned DW    = 32,
  parameter int unsigned STALL = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          up_valid,
  input  logic [DW-1:0] up_data,
  output logic          up_ready,
  output logic [31:0]   rx_cnt,
  output logic [15:0]   err_cnt,
  output logic          err_flag,
  output logic          mismatch
);

  if (DW < 1 || DW > 32 || STALL > 65535) begin : g_param_range
    $error("stream_checker: DW must be 1..32 and STALL 0..65535");
  end

`ifdef STREAM_CHECKER_STALL_EN
  typedef enum logic [1:0] {WAIT, ACCEPT, HOLD} state_t;
  localparam logic [15:0] STALL_LD = (STALL > 0) ? 16'(STALL - 1) : '0;
  logic [15:0] stall_cnt;
`else
  typedef enum logic [1:0] {WAIT, ACCEPT} state_t;
`endif

  state_t        state;
  logic [DW-1:0] exp;
  logic          accept;

  assign accept = up_valid & up_ready;

  // up_ready is registered alongside the state so it always mirrors the state held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= WAIT;
      up_ready <= 1'b0;
`ifdef STREAM_CHECKER_STALL_EN
      stall_cnt <= '0;
`endif
    end else begin
      case (state)
        WAIT: begin
          state    <= ACCEPT;
          up_ready <= 1'b1;
        end
        ACCEPT: begin
`ifdef STREAM_CHECKER_STALL_EN
          if (accept && (STALL > 0)) begin
            state     <= HOLD;
            up_ready  <= 1'b0;
            stall_cnt <= STALL_LD;
          end
`endif
        end
`ifdef STREAM_CHECKER_STALL_EN
        HOLD: begin
          if (stall_cnt == '0) begin
            state    <= ACCEPT;
            up_ready <= 1'b1;
          end else begin
            stall_cnt <= stall_cnt - 16'd1;
          end
        end
`endif
        default: begin
          state    <= WAIT;
          up_ready <= 1'b0;
        end
      endcase
    end
  end

  // A mismatch resynchronises exp to the received value so one bad beat costs one error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp      <= '0;
      rx_cnt   <= '0;
      err_cnt  <= '0;
      err_flag <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      if (accept) begin
        rx_cnt <= rx_cnt + 32'd1;
        if (up_data == exp) begin
          exp <= exp + DW'(1);
        end else begin
          exp      <= up_data + DW'(1);
          err_flag <= 1'b1;
          mismatch <= 1'b1;
          if (err_cnt != '1) err_cnt <= err_cnt + 16'd1;
        end
      end
    end
  end

endmodule
